// File: rtl/tt_wb_ctrl_pkg.sv
// Shared constants for the Wishbone mux-chain controller: register map,
// CTRL/STATUS bit positions and the selection sequencer state encoding.
package tt_wb_ctrl_pkg;

    localparam logic [1:0] REG_ID     = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_SEL    = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_ENA    = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_BUSY   = 8;

    localparam int STAT_DONE = 0;
    localparam int STAT_ERR  = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_GAP,
        S_INC_HI,
        S_INC_LO,
        S_FIN
    } seq_state_t;

endpackage

// File: rtl/tt_sel_seq.sv
// Selection sequencer: pulses the mux counter reset low, then emits exactly
// `target` increment pulses, each PULSE_CYCLES high and PULSE_CYCLES low.
module tt_sel_seq
    import tt_wb_ctrl_pkg::*;
#(
    parameter int N_ADDR       = 10,
    parameter int PULSE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              start,
    input  logic [N_ADDR-1:0] target,
    output logic              busy,
    output logic              busy_next,
    output logic              done,
    output logic              sel_rst_n,
    output logic              sel_inc
);

    localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);

    seq_state_t        state_reg, state_next;
    logic [PW-1:0]     pcnt_reg, pcnt_next;
    logic [N_ADDR-1:0] cnt_reg, cnt_next;
    logic              pulse_end;

    assign pulse_end = (pcnt_reg == PULSE_LAST);

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= S_IDLE;
            pcnt_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pcnt_reg  <= pcnt_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pcnt_next  = pcnt_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RST;
                    pcnt_next  = '0;
                    cnt_next   = '0;
                end
            end
            S_RST: begin
                if (pulse_end) begin
                    state_next = S_GAP;
                    pcnt_next  = '0;
                end else begin
                    pcnt_next = pcnt_reg + 1'b1;
                end
            end
            S_GAP: begin
                state_next = (target != '0) ? S_INC_HI : S_FIN;
            end
            S_INC_HI: begin
                if (pulse_end) begin
                    state_next = S_INC_LO;
                    pcnt_next  = '0;
                end else begin
                    pcnt_next = pcnt_reg + 1'b1;
                end
            end
            S_INC_LO: begin
                if (pulse_end) begin
                    pcnt_next = '0;
                    cnt_next  = cnt_reg + 1'b1;
                    // Extra bit keeps the compare exact for target = 2^N_ADDR-1.
                    state_next = (({1'b0, cnt_reg} + 1'b1) == {1'b0, target}) ? S_FIN : S_INC_HI;
                end else begin
                    pcnt_next = pcnt_reg + 1'b1;
                end
            end
            S_FIN: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = (state_reg != S_IDLE);
        busy_next = (state_next != S_IDLE);
        done      = (state_reg == S_FIN);
        sel_rst_n = (state_reg != S_RST);
        sel_inc   = (state_reg == S_INC_HI);
    end

endmodule

// File: rtl/tt_wb_ctrl.sv
// Wishbone classic slave exposing ID/CTRL/SEL/STATUS registers and driving the
// project mux-chain control lines through the selection sequencer.
module tt_wb_ctrl
    import tt_wb_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter logic [31:0] ID_VALUE     = 32'h5454_0001,
    parameter int          N_ADDR       = 10,
    parameter int          PULSE_CYCLES = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        ctrl_sel_rst_n,
    output logic        ctrl_sel_inc,
    output logic        ctrl_ena,
    output logic        irq_o
);

    logic              ack_reg;
    logic [31:0]       dat_reg;
    logic              ena_reg, irq_en_reg, done_reg, err_reg, ctrl_ena_reg;
    logic [N_ADDR-1:0] sel_reg;
    logic              hit, wr_en, wr_ctrl, wr_sel, wr_status;
    logic              seq_start, busy_write, ena_next;
    logic              seq_busy, seq_busy_next, seq_done;
    logic [1:0]        reg_idx;
    logic [31:0]       rdata;
    logic              unused_bits;

    assign unused_bits = ^{wbs_sel_i[3:2], wbs_adr_i[1:0], wbs_dat_i[31:N_ADDR]};

    // The !ack term forces a one-cycle gap between back-to-back accesses.
    assign hit        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & !ack_reg;
    assign wr_en      = hit & wbs_we_i & (wbs_sel_i[1:0] == 2'b11);
    assign reg_idx    = wbs_adr_i[3:2];
    assign wr_ctrl    = wr_en & (reg_idx == REG_CTRL);
    assign wr_sel     = wr_en & (reg_idx == REG_SEL);
    assign wr_status  = wr_en & (reg_idx == REG_STATUS);
    assign seq_start  = wr_sel & !seq_busy;
    assign busy_write = wr_sel & seq_busy;
    assign ena_next   = wr_ctrl ? wbs_dat_i[CTRL_ENA] : ena_reg;

    always_comb begin
        rdata = '0;
        case (reg_idx)
            REG_ID: rdata = ID_VALUE;
            REG_CTRL: begin
                rdata[CTRL_ENA]    = ena_reg;
                rdata[CTRL_IRQ_EN] = irq_en_reg;
                rdata[CTRL_BUSY]   = seq_busy;
            end
            REG_SEL: rdata[N_ADDR-1:0] = sel_reg;
            REG_STATUS: begin
                rdata[STAT_DONE] = done_reg;
                rdata[STAT_ERR]  = err_reg;
            end
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_reg      <= 1'b0;
            dat_reg      <= '0;
            ena_reg      <= 1'b0;
            irq_en_reg   <= 1'b0;
            sel_reg      <= '0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            ctrl_ena_reg <= 1'b0;
        end else begin
            ack_reg <= hit;
            dat_reg <= hit ? rdata : '0;
            if (wr_ctrl) begin
                ena_reg    <= wbs_dat_i[CTRL_ENA];
                irq_en_reg <= wbs_dat_i[CTRL_IRQ_EN];
            end
            if (seq_start) begin
                sel_reg <= wbs_dat_i[N_ADDR-1:0];
            end
            // Set events take priority over write-1-to-clear.
            done_reg <= seq_done | (done_reg & !(wr_status & wbs_dat_i[STAT_DONE]));
            err_reg  <= busy_write | (err_reg & !(wr_status & wbs_dat_i[STAT_ERR]));
            // Looking at next-cycle busy lets ena fall together with BUSY.
            ctrl_ena_reg <= ena_next & !seq_busy_next;
        end
    end

    tt_sel_seq #(
        .N_ADDR       (N_ADDR),
        .PULSE_CYCLES (PULSE_CYCLES)
    ) u_seq (
        .clk       (wb_clk_i),
        .srst      (wb_rst_i),
        .start     (seq_start),
        .target    (sel_reg),
        .busy      (seq_busy),
        .busy_next (seq_busy_next),
        .done      (seq_done),
        .sel_rst_n (ctrl_sel_rst_n),
        .sel_inc   (ctrl_sel_inc)
    );

    assign wbs_ack_o = ack_reg;
    assign wbs_dat_o = dat_reg;
    assign ctrl_ena  = ctrl_ena_reg;
    assign irq_o     = done_reg & irq_en_reg;

endmodule

// File: tb/tb_tt_wb_ctrl.sv
// Directed bench for tt_wb_ctrl: register access, selection sequences,
// busy-write error, bus corner cases and mid-sequence reset.
module tb_tt_wb_ctrl;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i, wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, irq_o;

    int n_vec  = 0;
    int n_miss = 0;

    localparam logic [31:0] A_ID     = 32'h3000_0000;
    localparam logic [31:0] A_CTRL   = 32'h3000_0004;
    localparam logic [31:0] A_SEL    = 32'h3000_0008;
    localparam logic [31:0] A_STATUS = 32'h3000_000C;

    always #5 wb_clk_i = ~wb_clk_i;

    tt_wb_ctrl dut (
        .wb_clk_i       (wb_clk_i),
        .wb_rst_i       (wb_rst_i),
        .wbs_stb_i      (wbs_stb_i),
        .wbs_cyc_i      (wbs_cyc_i),
        .wbs_we_i       (wbs_we_i),
        .wbs_sel_i      (wbs_sel_i),
        .wbs_dat_i      (wbs_dat_i),
        .wbs_adr_i      (wbs_adr_i),
        .wbs_ack_o      (wbs_ack_o),
        .wbs_dat_o      (wbs_dat_o),
        .ctrl_sel_rst_n (ctrl_sel_rst_n),
        .ctrl_sel_inc   (ctrl_sel_inc),
        .ctrl_ena       (ctrl_ena),
        .irq_o          (irq_o)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after ack or after 4 cycles.
    task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                             input logic [3:0] sel, output logic [31:0] rdat,
                             output logic acked, output int lat);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = wdat;
        wbs_sel_i = sel;
        acked = 1'b0;
        rdat  = '0;
        lat   = 0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge wb_clk_i);
            #1;
            if (wbs_ack_o) begin
                acked = 1'b1;
                rdat  = wbs_dat_o;
                lat   = i;
                break;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        $display("wb %s adr=%h wdat=%h sel=%b -> ack=%0d rdat=%h lat=%0d",
                 we ? "wr" : "rd", adr, wdat, sel, acked, rdat, lat);
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] wdat, input string tag);
        logic [31:0] rd;
        logic        ak;
        int          lt;
        wb_access(1'b1, adr, wdat, 4'hF, rd, ak, lt);
        check_val(tag, 32'(ak), 32'd1);
    endtask

    task automatic wb_read_chk(input logic [31:0] adr, input logic [31:0] exp, input string tag);
        logic [31:0] rd;
        logic        ak;
        int          lt;
        wb_access(1'b0, adr, 32'h0, 4'hF, rd, ak, lt);
        check_val(tag, ak ? rd : 32'hDEAD_DEAD, exp);
    endtask

    // Samples control outputs for n cycles starting at the current posedge+1.
    task automatic observe(input int n, output int rst_low, output int rises,
                           output int inc_hi, output int ena_low);
        logic prev;
        prev = 1'b0;
        rst_low = 0; rises = 0; inc_hi = 0; ena_low = 0;
        for (int i = 0; i < n; i++) begin
            if (!ctrl_sel_rst_n) rst_low++;
            if (ctrl_sel_inc) inc_hi++;
            if (ctrl_sel_inc && !prev) rises++;
            if (!ctrl_ena) ena_low++;
            prev = ctrl_sel_inc;
            @(posedge wb_clk_i);
            #1;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        ak, ak2;
        int          lt, lt2;
        int          rl, ri, ih, el;

        wb_rst_i  = 1'b1;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'h0;
        wbs_dat_i = '0;
        wbs_adr_i = '0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;

        check_val("rst_ack", 32'(wbs_ack_o), 32'd0);
        check_val("rst_dat", wbs_dat_o, 32'd0);
        check_val("rst_sel_rst_n", 32'(ctrl_sel_rst_n), 32'd1);
        check_val("rst_inc", 32'(ctrl_sel_inc), 32'd0);
        check_val("rst_ena", 32'(ctrl_ena), 32'd0);
        check_val("rst_irq", 32'(irq_o), 32'd0);

        wb_access(1'b0, A_ID, 32'h0, 4'hF, rd, ak, lt);
        check_val("id_lat", 32'(lt), 32'd1);
        check_val("id_dat", rd, 32'h5454_0001);
        @(posedge wb_clk_i);
        #1;
        check_val("ack_one_cycle", 32'(wbs_ack_o), 32'd0);
        check_val("idle_dat_zero", wbs_dat_o, 32'd0);
        wb_read_chk(A_STATUS, 32'h0, "status_rst");
        wb_write(A_ID, 32'hFFFF_FFFF, "id_wr_ack");
        wb_read_chk(A_ID, 32'h5454_0001, "id_ro");

        // SEL=3: 4 + 2 + 2*4*3 = 30 busy cycles
        wb_write(A_CTRL, 32'h1, "ctrl_wr");
        wb_read_chk(A_CTRL, 32'h1, "ctrl_rd");
        wb_write(A_SEL, 32'd3, "sel3_wr");
        observe(40, rl, ri, ih, el);
        check_val("sel3_rst_low", 32'(rl), 32'd4);
        check_val("sel3_rises", 32'(ri), 32'd3);
        check_val("sel3_inc_hi", 32'(ih), 32'd12);
        check_val("sel3_ena_low", 32'(el), 32'd30);
        check_val("sel3_ena_after", 32'(ctrl_ena), 32'd1);
        wb_read_chk(A_STATUS, 32'h1, "sel3_status");
        wb_read_chk(A_SEL, 32'd3, "sel3_rdback");

        // SEL=0: reset pulse only, 6 busy cycles
        wb_write(A_SEL, 32'd0, "sel0_wr");
        observe(15, rl, ri, ih, el);
        check_val("sel0_rst_low", 32'(rl), 32'd4);
        check_val("sel0_rises", 32'(ri), 32'd0);
        check_val("sel0_ena_low", 32'(el), 32'd6);
        wb_read_chk(A_STATUS, 32'h1, "sel0_status");
        wb_write(A_STATUS, 32'h1, "w1c_wr");
        wb_read_chk(A_STATUS, 32'h0, "w1c_cleared");

        // SEL=5 with a busy SEL=7 write at cycle 10: 4 + 2 + 40 = 46 busy
        wb_write(A_CTRL, 32'h3, "ctrl_irq_wr");
        wb_write(A_SEL, 32'd5, "sel5_wr");
        fork
            observe(60, rl, ri, ih, el);
            begin
                repeat (9) @(posedge wb_clk_i);
                #1;
                wb_access(1'b1, A_SEL, 32'd7, 4'hF, rd, ak, lt);
                wb_access(1'b0, A_CTRL, 32'h0, 4'hF, rd, ak2, lt2);
            end
        join
        check_val("busy_wr_ack", 32'(ak), 32'd1);
        check_val("ctrl_busy_rd", ak2 ? rd : 32'hDEAD_DEAD, 32'h103);
        check_val("sel5_rises", 32'(ri), 32'd5);
        check_val("sel5_inc_hi", 32'(ih), 32'd20);
        check_val("sel5_ena_low", 32'(el), 32'd46);
        wb_read_chk(A_SEL, 32'd5, "sel5_rdback");
        wb_read_chk(A_STATUS, 32'h3, "sel5_status");
        check_val("irq_set", 32'(irq_o), 32'd1);
        wb_write(A_STATUS, 32'h3, "w1c_both");
        wb_read_chk(A_STATUS, 32'h0, "status_clr_both");
        check_val("irq_clr", 32'(irq_o), 32'd0);

        // Out-of-window access and partial-lane write
        wb_access(1'b0, 32'h3000_0010, 32'h0, 4'hF, rd, ak, lt);
        check_val("miss_noack", 32'(ak), 32'd0);
        wb_access(1'b1, A_CTRL, 32'h0, 4'b0001, rd, ak, lt);
        check_val("partial_ack", 32'(ak), 32'd1);
        wb_read_chk(A_CTRL, 32'h3, "partial_noeffect");

        // SEL=20 then reset during an increment-high phase
        wb_write(A_SEL, 32'd20, "sel20_wr");
        ak = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (ctrl_sel_inc) begin
                ak = 1'b1;
                break;
            end
            @(posedge wb_clk_i);
            #1;
        end
        check_val("inc_seen", 32'(ak), 32'd1);
        @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        check_val("mrst_inc", 32'(ctrl_sel_inc), 32'd0);
        check_val("mrst_rst_n", 32'(ctrl_sel_rst_n), 32'd1);
        check_val("mrst_ena", 32'(ctrl_ena), 32'd0);
        wb_read_chk(A_CTRL, 32'h0, "mrst_ctrl");
        wb_read_chk(A_SEL, 32'h0, "mrst_sel");
        wb_read_chk(A_STATUS, 32'h0, "mrst_status");
        observe(40, rl, ri, ih, el);
        check_val("mrst_no_rises", 32'(ri), 32'd0);
        check_val("mrst_no_rst", 32'(rl), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/tt_wb_ctrl.md
Name: tt_wb_ctrl

Overview:
- Wishbone classic slave inside the user wrapper, between the Caravel management bus and tt_top.
- Replaces the current bus tie-offs with a small register file.
- Drives the mux-chain control lines (design-select reset, increment pulses, enable) so firmware can select a project by address instead of bit-banging GPIO.
- Raises user_irq[0] when a selection sequence completes.

Parameters:
- BASE_ADDR, 32'h3000_0000, base of the 16-byte register window; adr_i[31:4] must match BASE_ADDR[31:4].
- ID_VALUE, 32'h5454_0001, value returned by the ID register.
- N_ADDR, 10, width of the design-select address.
- PULSE_CYCLES, 4, width in wb_clk_i cycles of each sel_rst low phase, inc high phase and inc low phase (min 1).

Ports:
- wb_clk_i  input  1  single clock for the whole block
- wb_rst_i  input  1  synchronous active-high reset
- wbs_stb_i  input  1  Wishbone strobe
- wbs_cyc_i  input  1  Wishbone cycle
- wbs_we_i  input  1  write enable
- wbs_sel_i  input  4  byte lane select
- wbs_dat_i  input  32  write data
- wbs_adr_i  input  32  byte address
- wbs_ack_o  output  1  acknowledge
- wbs_dat_o  output  32  read data
- ctrl_sel_rst_n  output  1  active-low reset of the mux address counter
- ctrl_sel_inc  output  1  mux address increment pulse
- ctrl_ena  output  1  enable of the selected design
- irq_o  output  1  level interrupt; DONE & IRQ_EN

Behaviour:
- Reset (wb_rst_i=1 at a clock edge):
  - Outputs: ack=0, dat_o=0, ctrl_sel_rst_n=1, ctrl_sel_inc=0, ctrl_ena=0, irq_o=0.
  - All registers clear; FSM goes to IDLE.
  - Reset mid-sequence aborts immediately, with no further pulses.
- Bus access:
  - Hit = cyc & stb & (adr[31:4]==BASE[31:4]) & !ack.
  - ack is asserted the cycle after a hit, for exactly one cycle. Back-to-back accesses therefore ack every other cycle.
  - Misses are never acked.
  - dat_o is valid with ack and 0 otherwise.
  - Writes commit on the hit cycle only when wbs_sel_i[1:0]==2'b11; other sel patterns are acked with no effect.
- Register map (offset adr[3:2]):
  - 0x0 ID: RO, returns ID_VALUE; writes ignored.
  - 0x4 CTRL: bit0 ENA (RW), bit1 IRQ_EN (RW), bit8 BUSY (RO).
  - 0x8 SEL: bits[N_ADDR-1:0] target (RW, read returns last accepted target).
    - A write while !BUSY latches the target and starts the sequence.
    - A write while BUSY is acked, does not change the target, and sets ERR.
  - 0xC STATUS: bit0 DONE, bit1 ERR; both sticky, write-1-to-clear. A set event wins over a clear in the same cycle.
- Sequencer FSM, states IDLE, RST, GAP, INC_HI, INC_LO, FIN:
  - IDLE: on an accepted SEL write, counter=0, go to RST next cycle, BUSY=1.
  - RST: ctrl_sel_rst_n=0 for PULSE_CYCLES cycles, then GAP.
  - GAP: 1 cycle, then INC_HI if target!=0, else FIN.
  - INC_HI: ctrl_sel_inc=1 for PULSE_CYCLES cycles, then INC_LO.
  - INC_LO: inc=0 for PULSE_CYCLES cycles; counter++; go to FIN if counter+1==target, else INC_HI.
  - FIN: 1 cycle, set DONE, BUSY=0, go to IDLE.
  - Exactly `target` rising edges of ctrl_sel_inc are produced. Target max 2^N_ADDR-1, with no wrap.
  - Total busy time = PULSE_CYCLES + 2 + 2*PULSE_CYCLES*target cycles, counted from the first RST cycle to FIN inclusive.
- ctrl_ena = ENA & !BUSY, registered. It drops in the same cycle BUSY rises and returns the cycle after FIN.
- Simultaneous SEL write and FIN: FIN completes first (BUSY still 1 at the hit), so the write counts as a busy write and sets ERR.

Decomposition:
- Package tt_wb_ctrl_pkg holds:
  - Register offset constants (REG_ID, REG_CTRL, REG_SEL, REG_STATUS).
  - CTRL/STATUS bit index constants.
  - FSM state enum seq_state_t.
- One sub-module is natural: tt_sel_seq, containing the FSM, pulse-width counter and increment counter. Its interface is start/target in, busy/done out, plus the two ctrl_sel lines.
- Bus decode and registers stay in the top module.

Test Plan:
- Reset, then read 0x3000_0000 -> ack exactly 1 cycle after stb, dat=32'h5454_0001; read 0x3000_000C -> 0; ctrl_sel_rst_n=1, inc=0, ena=0.
- Write CTRL=0x1, then SEL=3 (PULSE_CYCLES=4) -> sel_rst_n low 4 cycles, 3 inc pulses each 4 high/4 low, BUSY for 30 cycles, ena low during and high after, STATUS=0x1.
- SEL=0 -> rst_n low 4 cycles, no inc pulses, DONE after 6 busy cycles; write STATUS=0x1 -> STATUS reads 0.
- SEL=5, then at cycle 10 write SEL=7 -> ack issued, exactly 5 inc pulses, SEL reads 5, STATUS=0x3.
- Access 0x3000_0010 and a write with sel=4'b0001 -> no ack for the miss; ack with no register change for the partial write.
- Start SEL=20, assert wb_rst_i mid-INC_HI for 1 cycle -> next cycle inc=0, rst_n=1, BUSY=0, all registers 0, no further pulses.
